// File: rtl/configs_pkg.sv
// Shared sizing constants and loader state encoding for the configuration store.
package configs_pkg;

  localparam int unsigned CFG_WORD_W    = 32;
  localparam int unsigned CFG_NUM_WORDS = 15;
  localparam int unsigned CFG_IDX_W     = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSetup,
    StStrobe,
    StHold,
    StDone
  } loader_state_e;

endpackage

// File: rtl/cfg_onehot_dec.sv
// Group-index to one-hot enable decoder, gated by a strobe qualifier.
module cfg_onehot_dec
  import configs_pkg::*;
#(
  parameter int unsigned NUM_WORDS = CFG_NUM_WORDS,
  parameter int unsigned IDX_W     = CFG_IDX_W
) (
  input  logic [IDX_W-1:0]     idx,
  input  logic                 strobe,
  output logic [NUM_WORDS-1:0] onehot
);

  // At most one bit set, and only while strobe is high.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      if (strobe && (idx == IDX_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/configs_loader.sv
// Write-side sequencer for the configuration latch bank: accepts words over
// valid/ready and drives a setup/strobe/hold sequence per latch group.
module configs_loader
  import configs_pkg::*;
#(
  parameter int unsigned WORD_W    = CFG_WORD_W,
  parameter int unsigned NUM_WORDS = CFG_NUM_WORDS,
  parameter int unsigned IDX_W     = CFG_IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_word_valid,
  output logic                 io_word_ready,
  input  logic [WORD_W-1:0]    io_word,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic [IDX_W-1:0]     io_word_idx,
  output logic                 io_busy,
  output logic                 io_done
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_WORDS - 1);

  loader_state_e        state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0]    d_out_q, d_out_d;
  logic [NUM_WORDS-1:0] en_q, en_d;

  // Next-state, index and data-bus update; the bus only loads on a handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    d_out_d = d_out_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (io_start) begin
          idx_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (io_word_valid) begin
          d_out_d = io_word;
          state_d = StSetup;
        end
      end
      StSetup:  state_d = StStrobe;
      StStrobe: state_d = StHold;
      StHold: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Enable is decoded from the upcoming state so the flop is high exactly in STROBE.
  cfg_onehot_dec #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_dec (
    .idx    (idx_q),
    .strobe (state_d == StStrobe),
    .onehot (en_d)
  );

  // State, index, data bus and enable registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      d_out_q <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_out_q <= d_out_d;
      en_q    <= en_d;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    io_word_ready = (state_q == StLoad);
    io_busy       = (state_q == StLoad) || (state_q == StSetup) ||
                    (state_q == StStrobe) || (state_q == StHold);
    io_done       = (state_q == StDone);
  end

  assign io_d_out      = d_out_q;
  assign io_configs_en = en_q;
  assign io_word_idx   = idx_q;

endmodule

// File: tb/tb_configs_loader.sv
// Scoreboard bench for configs_loader: driver pushes expected strobes, monitor
// pops them when an enable fires and mirrors a latch bank for readback.
`timescale 1ns/1ps
module tb_configs_loader;
  import configs_pkg::*;

  localparam int NW = CFG_NUM_WORDS;
  localparam int WW = CFG_WORD_W;
  localparam int IW = CFG_IDX_W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          io_start = 1'b0;
  logic          io_word_valid = 1'b0;
  logic          io_word_ready;
  logic [WW-1:0] io_word = '0;
  logic [WW-1:0] io_d_out;
  logic [NW-1:0] io_configs_en;
  logic [IW-1:0] io_word_idx;
  logic          io_busy;
  logic          io_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [WW-1:0] word;
  } exp_t;

  exp_t          sb[$];
  exp_t          got;
  logic [WW-1:0] latch_mdl [NW];
  logic          rst_at_edge = 1'b1;
  logic [WW-1:0] d_prev;
  logic [NW-1:0] en_prev = '0;

  configs_loader dut (
    .clk           (clk),
    .reset         (reset),
    .io_start      (io_start),
    .io_word_valid (io_word_valid),
    .io_word_ready (io_word_ready),
    .io_word       (io_word),
    .io_d_out      (io_d_out),
    .io_configs_en (io_configs_en),
    .io_word_idx   (io_word_idx),
    .io_busy       (io_busy),
    .io_done       (io_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] pat(input int sel, input int k);
    case (sel)
      0:       return WW'(k);
      1:       return 32'hA5A5_A5A5 ^ WW'(k);
      2:       return 32'h0000_1000 + WW'(k);
      default: return 32'hC0DE_0000 | WW'(k);
    endcase
  endfunction

  // Monitor: scoreboard pop on every strobe, latch model, one-hot and bus stability.
  always @(negedge clk) begin
    check("en_popcount_le1", 64'($countones(io_configs_en) <= 1), 64'd1);
    if (io_configs_en != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 64'(io_configs_en), 64'd0);
      end else begin
        got = sb.pop_front();
        check("strobe_en", 64'(io_configs_en), 64'(NW'(1) << got.idx));
        check("strobe_data", 64'(io_d_out), 64'(got.word));
        check("strobe_idx", 64'(io_word_idx), 64'(got.idx));
      end
      for (int i = 0; i < NW; i++) begin
        if (io_configs_en[i]) latch_mdl[i] = io_d_out;
      end
    end
    if (!rst_at_edge) begin
      if (io_configs_en != '0 && en_prev == '0)
        check("bus_stable_before_rise", 64'(io_d_out), 64'(d_prev));
      if (io_configs_en == '0 && en_prev != '0)
        check("bus_stable_after_fall", 64'(io_d_out), 64'(d_prev));
    end
    d_prev  = io_d_out;
    en_prev = io_configs_en;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_d_out"}, 64'(io_d_out), 64'd0);
    check({tag, "_en"}, 64'(io_configs_en), 64'd0);
    check({tag, "_ready"}, 64'(io_word_ready), 64'd0);
    check({tag, "_idx"}, 64'(io_word_idx), 64'd0);
    check({tag, "_busy"}, 64'(io_busy), 64'd0);
    check({tag, "_done"}, 64'(io_done), 64'd0);
  endtask

  // Driver: start, then offer words; optional stalls, mid-sequence start, or reset.
  task automatic run_load(input int sel, input int stall_a, input int stall_b,
                          input int pulse_k, input int reset_k, output int edge_s);
    int wait_n;
    @(negedge clk);
    io_start = 1'b1;
    @(negedge clk);
    io_start = 1'b0;
    edge_s = cyc;
    check("start_ready", 64'(io_word_ready), 64'd1);
    check("start_busy", 64'(io_busy), 64'd1);
    check("start_done_clear", 64'(io_done), 64'd0);
    check("start_idx", 64'(io_word_idx), 64'd0);
    for (int k = 0; k < NW; k++) begin
      io_word = pat(sel, k);
      if (k == stall_a || k == stall_b) begin
        io_word_valid = 1'b0;
        wait_n = 0;
        while (!io_word_ready && wait_n < 20) begin
          @(negedge clk);
          wait_n++;
        end
        for (int j = 0; j < 3; j++) begin
          check("stall_ready", 64'(io_word_ready), 64'd1);
          check("stall_idx", 64'(io_word_idx), 64'(k));
          check("stall_no_en", 64'(io_configs_en), 64'd0);
          @(negedge clk);
        end
      end
      io_word_valid = 1'b1;
      wait_n = 0;
      while (!io_word_ready && wait_n < 20) begin
        @(negedge clk);
        wait_n++;
      end
      if (!io_word_ready) begin
        check("ready_timeout", 64'd0, 64'd1);
        io_word_valid = 1'b0;
        return;
      end
      sb.push_back(exp_t'{idx: IW'(k), word: pat(sel, k)});
      @(negedge clk);
      check("setup_not_ready", 64'(io_word_ready), 64'd0);
      check("setup_idx", 64'(io_word_idx), 64'(k));
      if (k == pulse_k) begin
        io_start = 1'b1;
        @(negedge clk);
        io_start = 1'b0;
        check("start_ignored_idx", 64'(io_word_idx), 64'(k));
        check("start_ignored_busy", 64'(io_busy), 64'd1);
      end
      if (k == reset_k) begin
        @(negedge clk);
        check("strobe_before_reset", 64'(io_configs_en), 64'(NW'(1) << k));
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_reset");
        reset = 1'b0;
        io_word_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_done(input int edge_s, input int exp_lat, input string name);
    int n;
    n = 0;
    while (!io_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    // done first visible after edge S+exp_lat, i.e. in cycle S+exp_lat+1
    check(name, 64'(cyc - edge_s), 64'(exp_lat));
    check("done_not_busy", 64'(io_busy), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("done_held", 64'(io_done), 64'd1);
    check("done_not_ready", 64'(io_word_ready), 64'd0);
    io_word_valid = 1'b0;
  endtask

  task automatic readback(input int sel, input string name);
    for (int k = 0; k < NW; k++) check(name, 64'(latch_mdl[k]), 64'(pat(sel, k)));
  endtask

  initial begin
    int s;
    for (int k = 0; k < NW; k++) latch_mdl[k] = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;

    // Valid while idle must not load the bus.
    io_word = 32'hDEAD_BEEF;
    io_word_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_valid_ignored", 64'(io_d_out), 64'd0);
    check("idle_not_ready", 64'(io_word_ready), 64'd0);

    // Plain full load, words 0..14.
    run_load(0, -1, -1, -1, -1, s);
    wait_done(s, 4 * NW, "done_latency");
    readback(0, "readback_plain");

    // Stalls before words 0 and 7 add 6 cycles.
    run_load(3, 0, 7, -1, -1, s);
    wait_done(s, 4 * NW + 6, "done_latency_stall");
    readback(3, "readback_stall");

    // Start pulsed during word 5 SETUP is ignored.
    run_load(0, -1, -1, 5, -1, s);
    wait_done(s, 4 * NW, "done_latency_pulse");
    readback(0, "readback_pulse");

    // Reset during word 9 STROBE: groups 0..9 new, 10..14 keep old contents.
    run_load(2, -1, -1, -1, 9, s);
    repeat (2) @(negedge clk);
    check_reset_vals("post_reset");
    check("sb_after_reset", 64'(sb.size()), 64'd0);
    for (int k = 0; k < NW; k++)
      check("readback_partial", 64'(latch_mdl[k]), 64'(k <= 9 ? pat(2, k) : pat(0, k)));

    // Restart from word 0, then a back-to-back load started from DONE.
    run_load(0, -1, -1, -1, -1, s);
    wait_done(s, 4 * NW, "done_latency_restart");
    readback(0, "readback_restart");
    run_load(1, -1, -1, -1, -1, s);
    wait_done(s, 4 * NW, "done_latency_b2b");
    readback(1, "readback_b2b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
